// File: rtl/key_debounce_mc.sv
// Multi-channel debouncer for active-low push-buttons: level, press/release pulses per key.
// Optional long-press pulse per key when KEY_LONG_PRESS_EN is defined.
module key_debounce_mc #(
    parameter int CLK_CYC = 10,
    parameter int KEY_NUM = 4,
    parameter int DEB_NS  = 10_000_000,
    parameter int LONG_NS = 1_000_000_000
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_out,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    localparam int               CNT_END  = DEB_NS / CLK_CYC;
    localparam int               CNT_W    = $clog2(CNT_END + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_END - 1);

`ifdef KEY_LONG_PRESS_EN
    localparam int                LONG_END  = LONG_NS / CLK_CYC;
    localparam int                LONG_W    = $clog2(LONG_END + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_END - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_END);
`endif

    logic [KEY_NUM-1:0] sync1_q;
    logic [KEY_NUM-1:0] sync2_q;

    // Pads idle high, so the synchroniser resets to the released level
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        logic             trig;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             out_q, out_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;

        always_comb begin
            trig    = out_q ^ sync2_q[i];
            cnt_d   = '0;
            out_d   = out_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            if (trig) begin
                if (cnt_q == CNT_LAST) begin
                    out_d   = sync2_q[i];
                    press_d = ~sync2_q[i];
                    rel_d   = sync2_q[i];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                out_q   <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign key_out[i]     = out_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;

`ifdef KEY_LONG_PRESS_EN
        logic [LONG_W-1:0] hold_q, hold_d;
        logic              long_q, long_d;

        // Saturating at LONG_END (one past the pulse point) gives one pulse per press
        always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            if (out_q) begin
                hold_d = '0;
            end else if (hold_q == LONG_LAST) begin
                hold_d = LONG_SAT;
                long_d = 1'b1;
            end else if (hold_q != LONG_SAT) begin
                hold_d = hold_q + LONG_W'(1);
            end
        end

        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign key_long[i] = long_q;
`else
        assign key_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce_mc.sv
// Scoreboard bench for key_debounce_mc: expected events queued at stimulus time, matched at the outputs.
module tb_key_debounce_mc;

    localparam int KN  = 4;
    localparam int LAT = 12;
`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_END = 50;
`endif

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;

    logic          sysclk = 1'b0;
    logic          rst_n;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_out;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;
    logic [KN-1:0] key_long;

    key_debounce_mc #(
        .CLK_CYC(10),
        .KEY_NUM(KN),
        .DEB_NS (100),
        .LONG_NS(500)
    ) u_dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ev(input int c, input int ch, input int kind);
        return {24'(c), 4'(ch), 4'(kind)};
    endfunction

    // Keep the queue ordered by (cycle, channel, kind) so pops follow output order
    task automatic sb_push(input int c, input int ch, input int kind);
        logic [31:0] v;
        int          idx;
        v   = ev(c, ch, kind);
        idx = 0;
        while (idx < sb.size() && sb[idx] <= v) idx++;
        sb.insert(idx, v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    always @(negedge sysclk) begin
        logic [31:0] got;
        logic [31:0] exp;
        logic        b;
        while (sb.size() > 0 && int'(sb[0][31:8]) < cyc) begin
            exp = sb.pop_front();
            chk("missed_event", 32'h0, exp);
        end
        for (int ch = 0; ch < KN; ch++) begin
            for (int k = 0; k < 3; k++) begin
                case (k)
                    K_PRESS: b = key_press[ch];
                    K_REL:   b = key_release[ch];
                    default: b = key_long[ch];
                endcase
                if (b === 1'b1) begin
                    got = ev(cyc, ch, k);
                    if (sb.size() > 0) begin
                        exp = sb.pop_front();
                        chk("event", got, exp);
                    end else begin
                        chk("unexpected_event", got, 32'h0);
                    end
                end
            end
        end
    end

    initial begin
        int k;
        rst_n  = 1'b0;
        key_in = '0;

        // 1: reset with all keys held down
        tick(3);
        chk("rst_key_out", 32'(key_out), 32'hF);
        chk("rst_press", 32'(key_press), 32'h0);
        chk("rst_rel_long", 32'({key_release, key_long}), 32'h0);
        rst_n = 1'b1;
        k = cyc;
        for (int ch = 0; ch < KN; ch++) sb_push(k + LAT, ch, K_PRESS);
        tick(LAT - 1);
        chk("t1_out_before", 32'(key_out), 32'hF);
        tick(1);
        chk("t1_out_after", 32'(key_out), 32'h0);
        tick(20);
        key_in = '1;
        k = cyc;
        for (int ch = 0; ch < KN; ch++) sb_push(k + LAT, ch, K_REL);
        tick(LAT);
        chk("t1_out_released", 32'(key_out), 32'hF);
        tick(3);

        // 2 + 5: bouncing ch0, then held low 100 cycles
        for (int r = 0; r < 3; r++) begin
            key_in[0] = 1'b0;
            tick(5);
            key_in[0] = 1'b1;
            tick(5);
        end
        chk("t2_no_change", 32'(key_out), 32'hF);
        key_in[0] = 1'b0;
        k = cyc;
        sb_push(k + LAT, 0, K_PRESS);
`ifdef KEY_LONG_PRESS_EN
        sb_push(k + LAT + LONG_END, 0, K_LONG);
`endif
        tick(LAT - 1);
        chk("t2_out_before", 32'(key_out), 32'hF);
        tick(1);
        chk("t2_out_after", 32'(key_out), 32'hE);
        tick(100 - LAT);
        key_in[0] = 1'b1;
        sb_push(cyc + LAT, 0, K_REL);
        tick(LAT + 3);

        // 3: ch1 press then release
        key_in[1] = 1'b0;
        sb_push(cyc + LAT, 1, K_PRESS);
        tick(20);
        key_in[1] = 1'b1;
        k = cyc;
        sb_push(k + LAT, 1, K_REL);
        tick(LAT - 1);
        chk("t3_out_before", 32'(key_out), 32'hD);
        tick(1);
        chk("t3_out_after", 32'(key_out), 32'hF);
        tick(3);

        // 4: ch2 pressed on the same cycle ch3 is released
        key_in[3] = 1'b0;
        sb_push(cyc + LAT, 3, K_PRESS);
        tick(20);
        key_in[2] = 1'b0;
        key_in[3] = 1'b1;
        k = cyc;
        sb_push(k + LAT, 2, K_PRESS);
        sb_push(k + LAT, 3, K_REL);
        tick(LAT);
        chk("t4_out", 32'(key_out), 32'hB);
        tick(8);
        key_in[2] = 1'b1;
        sb_push(cyc + LAT, 2, K_REL);
        tick(LAT + 3);

        // 6: reset in the middle of a pending press
        key_in[0] = 1'b0;
        sb_push(cyc + LAT, 0, K_PRESS);
        tick(15);
        key_in[1] = 1'b0;
        tick(9);
        chk("t6_pre_reset", 32'(key_out), 32'hE);
        rst_n = 1'b0;
        #1;
        chk("t6_async_out", 32'(key_out), 32'hF);
        chk("t6_async_ev", 32'({key_press, key_release, key_long}), 32'h0);
        tick(3);
        rst_n = 1'b1;
        k = cyc;
        sb_push(k + LAT, 0, K_PRESS);
        sb_push(k + LAT, 1, K_PRESS);
        tick(LAT - 1);
        chk("t6_out_before", 32'(key_out), 32'hF);
        tick(1);
        chk("t6_out_after", 32'(key_out), 32'hC);
        tick(5);
        key_in = '1;
        k = cyc;
        sb_push(k + LAT, 0, K_REL);
        sb_push(k + LAT, 1, K_REL);

        tick(60);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        chk("final_out", 32'(key_out), 32'hF);
        chk("final_long", 32'(key_long), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
